i2c_slave_ctrl: RTL and testbench

Byte-level controller for the I2C slave. It consumes the one-cycle Start/Stop pulses from the start/stop detector and the raw SCL/SDA lines, and sequences each transfer:
- address phase, R/W bit, ACK/NACK, data bytes, repeated start and stop;
- drives SDA low through an open-drain enable;
- gives the register-file side a simple byte handshake for writes (Rx) and reads (Tx).

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bit_shifter.sv | 35 +++
 rtl/i2c_slave_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and FSM state encoding for the I2C slave byte controller.
// Imported by i2c_bit_shifter and i2c_slave_ctrl.
package i2c_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_bit_shifter.sv
// MSB-first shift register with parallel load and a 4-bit bit counter.
// Ports: CLK, RST (async low), clr/load/shift controls, shift_in, load_data -> data, cnt.
module i2c_bit_shifter
  import i2c_pkg::*;
#(
  parameter int W = I2C_BYTE_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         shift_in,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic [3:0]   cnt
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      data <= {data[W-2:0], shift_in};
      cnt  <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte controller: address match, ACK, write (Rx) and read (Tx) bytes.
// Ports: CLK, RST, SCL, SDA, Start/Stop pulses, Tx_Data -> SDA_Drive_Low, Rx_*, Tx_Req, RW, Busy.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATA_WIDTH = I2C_BYTE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCL,
  input  logic                  SDA,
  input  logic                  Start_Condition,
  input  logic                  Stop_Condition,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  SDA_Drive_Low,
  output logic [DATA_WIDTH-1:0] Rx_Data,
  output logic                  Rx_Valid,
  output logic                  Tx_Req,
  output logic                  RW,
  output logic                  Busy
);

  i2c_state_t state;
  logic scl_q, scl_rise, scl_fall;
  // phase: in an ACK state, 0 = waiting for the fall that opens the
  // ACK bit, 1 = ACK bit in progress, next fall closes it
  logic phase;
  logic rx_pend;
  logic sh_clr, sh_load, sh_shift, sh_in;
  logic [DATA_WIDTH-1:0] sh_data, byte_nx;
  logic [3:0] sh_cnt;
  logic last_bit;

  assign scl_rise = SCL & ~scl_q;
  assign scl_fall = ~SCL & scl_q;
  assign last_bit = (sh_cnt == 4'd7);
  // the byte as it stands including the bit being sampled now
  assign byte_nx  = {sh_data[DATA_WIDTH-2:0], SDA};

  i2c_bit_shifter #(.W(DATA_WIDTH)) u_shift (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (sh_clr),
    .load     (sh_load),
    .shift    (sh_shift),
    .shift_in (sh_in),
    .load_data(Tx_Data),
    .data     (sh_data),
    .cnt      (sh_cnt)
  );

  always_comb begin
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_in    = SDA;
    if (Start_Condition || Stop_Condition) begin
      sh_clr = 1'b1;
    end else begin
      unique case (state)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            if (last_bit) sh_clr = 1'b1;
            else          sh_shift = 1'b1;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall && phase) begin
            if (RW) sh_load = 1'b1;
            else    sh_clr  = 1'b1;
          end
        end
        RD_DATA: begin
          sh_in = 1'b0;
          if (scl_fall) begin
            if (last_bit) sh_clr = 1'b1;
            else          sh_shift = 1'b1;
          end
        end
        RD_ACK: begin
          if (scl_fall && phase) sh_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      phase         <= 1'b0;
      rx_pend       <= 1'b0;
      scl_q         <= 1'b1;
      SDA_Drive_Low <= 1'b0;
      Rx_Data       <= '0;
      Rx_Valid      <= 1'b0;
      Tx_Req        <= 1'b0;
      RW            <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      scl_q    <= SCL;
      Tx_Req   <= 1'b0;
      rx_pend  <= 1'b0;
      Rx_Valid <= rx_pend;
      if (Stop_Condition) begin
        state         <= IDLE;
        phase         <= 1'b0;
        SDA_Drive_Low <= 1'b0;
        Busy          <= 1'b0;
      end else if (Start_Condition) begin
        state         <= ADDR;
        phase         <= 1'b0;
        SDA_Drive_Low <= 1'b0;
        Busy          <= 1'b0;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise && last_bit) begin
              if (byte_nx[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                RW    <= byte_nx[0];
                Busy  <= 1'b1;
                phase <= 1'b0;
                state <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall && !phase) begin
              SDA_Drive_Low <= ~I2C_ACK;
              phase         <= 1'b1;
            end else if (scl_fall) begin
              phase <= 1'b0;
              if (RW) begin
                SDA_Drive_Low <= ~Tx_Data[DATA_WIDTH-1];
                state         <= RD_DATA;
              end else begin
                SDA_Drive_Low <= 1'b0;
                state         <= WR_DATA;
              end
            end else if (scl_rise && phase && RW) begin
              Tx_Req <= 1'b1;
            end
          end
          WR_DATA: begin
            if (scl_rise && last_bit) begin
              Rx_Data <= byte_nx;
              rx_pend <= 1'b1;
              phase   <= 1'b0;
              state   <= WR_ACK;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (last_bit) begin
                SDA_Drive_Low <= 1'b0;
                phase         <= 1'b0;
                state         <= RD_ACK;
              end else begin
                SDA_Drive_Low <= ~sh_data[DATA_WIDTH-2];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !phase) begin
              if (SDA == I2C_NACK) begin
                state <= WAIT_STOP;
              end else begin
                Tx_Req <= 1'b1;
                phase  <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              SDA_Drive_Low <= ~Tx_Data[DATA_WIDTH-1];
              phase         <= 1'b0;
              state         <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: a bus-level master drives
// transactions; expectations come from a transaction-level model.
module tb_i2c_slave_ctrl;
  import i2c_pkg::*;

  localparam int Q = 4;
  localparam logic [6:0] SADDR = 7'h50;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SCL = 1'b1;
  logic m_sda = 1'b1;
  logic SDA;
  logic Start_Condition = 1'b0;
  logic Stop_Condition = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic SDA_Drive_Low, Rx_Valid, Tx_Req, RW, Busy;
  logic [7:0] Rx_Data;

  // open-drain wired-AND of master and slave
  assign SDA = m_sda & ~SDA_Drive_Low;

  always #5 CLK = ~CLK;

  i2c_slave_ctrl #(.SLAVE_ADDR(SADDR), .DATA_WIDTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .SCL            (SCL),
    .SDA            (SDA),
    .Start_Condition(Start_Condition),
    .Stop_Condition (Stop_Condition),
    .Tx_Data        (Tx_Data),
    .SDA_Drive_Low  (SDA_Drive_Low),
    .Rx_Data        (Rx_Data),
    .Rx_Valid       (Rx_Valid),
    .Tx_Req         (Tx_Req),
    .RW             (RW),
    .Busy           (Busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_txreq = 0;
  bit drove = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];

  always @(negedge CLK) begin
    if (Rx_Valid) rx_q.push_back(Rx_Data);
    if (Tx_Req) n_txreq++;
    if (SDA_Drive_Low) drove = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bit_io(input logic b, output logic seen);
    m_sda = b;
    cyc(Q);
    SCL = 1'b1;
    cyc(Q);
    seen = SDA;
    cyc(Q);
    SCL = 1'b0;
    cyc(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    cyc(Q);
    SCL = 1'b1;
    cyc(Q);
    m_sda = 1'b0;
    Start_Condition = 1'b1;
    cyc(1);
    Start_Condition = 1'b0;
    cyc(Q);
    SCL = 1'b0;
    cyc(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    cyc(Q);
    SCL = 1'b1;
    cyc(Q);
    m_sda = 1'b1;
    Stop_Condition = 1'b1;
    cyc(1);
    Stop_Condition = 1'b0;
    cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, input logic [7:0] nxt,
                         output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      got[i] = s;
    end
    Tx_Data = nxt;
    bit_io(mack, s);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rxn"}, rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      chk({tag, "_rx"}, rx_q[i], exp_rx[i]);
    rx_q.delete();
    exp_rx.delete();
  endtask

  // model: addressed iff address equals SADDR; every byte then ACKed
  // and delivered to Rx in order; otherwise NACK and nothing delivered
  task automatic xfer_wr(input string tag, input logic [6:0] a,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input int n);
    logic ack;
    bit hit;
    hit = (a == SADDR);
    drove = 0;
    start_c();
    wr_byte({a, 1'b0}, ack);
    chk({tag, "_aack"}, ack, hit ? I2C_ACK : I2C_NACK);
    chk({tag, "_busy"}, Busy, hit);
    if (n > 0) begin
      wr_byte(d0, ack);
      chk({tag, "_d0ack"}, ack, hit ? I2C_ACK : I2C_NACK);
      if (hit) exp_rx.push_back(d0);
    end
    if (n > 1) begin
      wr_byte(d1, ack);
      chk({tag, "_d1ack"}, ack, hit ? I2C_ACK : I2C_NACK);
      if (hit) exp_rx.push_back(d1);
    end
    stop_c();
    chk({tag, "_idle_busy"}, Busy, 1'b0);
    if (!hit) chk({tag, "_nodrive"}, drove, 1'b0);
    check_rx(tag);
  endtask

  // model: each byte read appears on the bus MSB first as presented;
  // one Tx_Req per byte (address ACK, then each master ACK)
  task automatic xfer_rd(input string tag, input int n,
                         input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2);
    logic ack;
    logic [7:0] got;
    logic [7:0] tx[4];
    tx[0] = t0;
    tx[1] = t1;
    tx[2] = t2;
    tx[3] = 8'h00;
    Tx_Data = tx[0];
    n_txreq = 0;
    start_c();
    wr_byte({SADDR, 1'b1}, ack);
    chk({tag, "_aack"}, ack, I2C_ACK);
    chk({tag, "_rw"}, RW, 1'b1);
    for (int i = 0; i < n; i++) begin
      rd_byte((i == n - 1) ? I2C_NACK : I2C_ACK, tx[i+1], got);
      chk({tag, "_byte"}, got, tx[i]);
    end
    chk({tag, "_rel"}, SDA_Drive_Low, 1'b0);
    chk({tag, "_wstop"}, dut.state, WAIT_STOP);
    chk({tag, "_txreq"}, n_txreq, n);
    stop_c();
    chk({tag, "_idle"}, dut.state, IDLE);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] got;
    logic [6:0] a;

    cyc(3);
    chk("rst_drv", SDA_Drive_Low, 1'b0);
    chk("rst_rxd", Rx_Data, 8'h00);
    chk("rst_rxv", Rx_Valid, 1'b0);
    chk("rst_txr", Tx_Req, 1'b0);
    chk("rst_rw", RW, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    RST = 1'b1;
    cyc(Q);

    xfer_wr("wr", SADDR, 8'hA5, 8'h3C, 2);
    xfer_wr("mis", 7'h51, 8'hFF, 8'h00, 1);
    xfer_rd("rd", 2, 8'hC3, 8'h81, 8'h00);

    for (int k = 0; k < 4; k++) begin
      a = 7'($urandom_range(0, 127));
      if (a == SADDR) a = 7'h2A;
      if ($urandom_range(0, 1) == 1) a = SADDR;
      xfer_wr("rwr", a, 8'($urandom), 8'($urandom), 2);
      xfer_rd("rrd", int'($urandom_range(1, 3)), 8'($urandom),
              8'($urandom), 8'($urandom));
    end

    // repeated start: write one byte, then read one byte
    Tx_Data = 8'h77;
    start_c();
    wr_byte({SADDR, 1'b0}, ack);
    chk("sr_aack", ack, I2C_ACK);
    wr_byte(8'h10, ack);
    chk("sr_dack", ack, I2C_ACK);
    exp_rx.push_back(8'h10);
    chk("sr_rw0", RW, 1'b0);
    start_c();
    wr_byte({SADDR, 1'b1}, ack);
    chk("sr_aack2", ack, I2C_ACK);
    chk("sr_rw1", RW, 1'b1);
    rd_byte(I2C_NACK, 8'h00, got);
    chk("sr_byte", got, 8'h77);
    stop_c();
    check_rx("sr");

    // abort after four data bits
    start_c();
    wr_byte({SADDR, 1'b0}, ack);
    for (int i = 0; i < 4; i++) bit_io(1'b1, s);
    stop_c();
    chk("ab_idle", dut.state, IDLE);
    chk("ab_rel", SDA_Drive_Low, 1'b0);
    chk("ab_busy", Busy, 1'b0);
    check_rx("ab");

    // asynchronous reset while the address ACK is driven
    start_c();
    for (int i = 7; i >= 0; i--) bit_io((i == 0) ? 1'b1 : SADDR[i-1], s);
    m_sda = 1'b1;
    cyc(Q);
    SCL = 1'b1;
    cyc(Q);
    chk("ar_drv", SDA_Drive_Low, 1'b1);
    chk("ar_rw", RW, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("ar_outs", {SDA_Drive_Low, Rx_Valid, Tx_Req, RW, Busy, Rx_Data},
        13'h0);
    chk("ar_idle", dut.state, IDLE);
    cyc(1);
    RST = 1'b1;
    SCL = 1'b0;
    cyc(Q);
    stop_c();

    // Start together with an SCL rise: start wins, counter stays 0
    SCL = 1'b0;
    cyc(Q);
    SCL = 1'b1;
    Start_Condition = 1'b1;
    cyc(1);
    Start_Condition = 1'b0;
    chk("sim_addr", dut.state, ADDR);
    chk("sim_cnt", dut.u_shift.cnt, 4'd0);
    cyc(Q);
    SCL = 1'b0;
    cyc(Q);
    wr_byte({SADDR, 1'b0}, ack);
    chk("sim_aack", ack, I2C_ACK);
    chk("sim_busy", Busy, 1'b1);
    // Start and Stop together: stop wins
    Start_Condition = 1'b1;
    Stop_Condition = 1'b1;
    cyc(1);
    Start_Condition = 1'b0;
    Stop_Condition = 1'b0;
    chk("ss_idle", dut.state, IDLE);
    chk("ss_busy", Busy, 1'b0);
    chk("ss_rel", SDA_Drive_Low, 1'b0);
    stop_c();
    check_rx("sim");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
